// File: rtl/sequenciador_de_busca.sv
// Fetch/step sequencer for the control unit.
// It generates the 2-bit step counter, owns the PC, and loads the instruction
// register (IIN) and the LDI immediate from the instruction ROM. It applies
// the PC update or conditional branch at the end of each instruction, and it
// freezes the machine when it decodes HLT.
// The branch offset is a 3-bit field, so ADDR_W must be at least 4.
module sequenciador_de_busca #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              run_i,
  input  logic [8:0]        mem_data_i,
  input  logic              pc_wr_enable_i,
  input  logic              branch_select_i,
  input  logic              rx_zero_i,
  output logic [1:0]        counter_o,
  output logic [8:0]        iin_o,
  output logic [8:0]        imm_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              halted_o
);

  // State code doubles as the step counter; S_HALT reads back as step 00.
  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_WRITE  = 3'b011,
    S_HALT   = 3'b100
  } state_t;

  localparam logic [2:0] OP_HLT = 3'b011;
  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [ADDR_W-1:0] PC_RESET_VAL = ADDR_W'(RESET_PC);

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [8:0]        iin_q;
  logic [8:0]        imm_q;
  logic              halted_q;

  logic [ADDR_W-1:0] pc_plus1_d;
  logic [ADDR_W-1:0] pc_plus2_d;
  logic [ADDR_W-1:0] pc_branch_d;
  logic [ADDR_W-1:0] pc_next_d;
  logic              is_ldi_d;
  logic              is_hlt_d;

  // Sign-extend the 3-bit branch offset to the PC width.
  function automatic logic [ADDR_W-1:0] sext_offset(input logic [2:0] off);
    return {{(ADDR_W-3){off[2]}}, off};
  endfunction

  // PC candidates and the end-of-instruction PC choice (branch > LDI > +1).
  always_comb begin
    is_ldi_d    = (iin_q[8:6] == OP_LDI);
    is_hlt_d    = (iin_q[8:6] == OP_HLT);
    pc_plus1_d  = pc_q + ADDR_W'(1);
    pc_plus2_d  = pc_q + ADDR_W'(2);
    pc_branch_d = pc_plus1_d + sext_offset(iin_q[2:0]);
    if (branch_select_i && rx_zero_i) begin
      pc_next_d = pc_branch_d;
    end else if (is_ldi_d) begin
      pc_next_d = pc_plus2_d;
    end else begin
      pc_next_d = pc_plus1_d;
    end
  end

  // ROM address: look one word ahead during decode to pick up an LDI immediate.
  always_comb begin
    case (state_q)
      S_DECODE: mem_addr_o = pc_plus1_d;
      default:  mem_addr_o = pc_q;
    endcase
  end

  // Sequencer FSM: step advance, IIN/IMM loads, PC update and halt latch.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= S_FETCH;
      pc_q     <= PC_RESET_VAL;
      iin_q    <= 9'h000;
      imm_q    <= 9'h000;
      halted_q <= 1'b0;
    end else if (run_i) begin
      case (state_q)
        S_FETCH: begin
          iin_q   <= mem_data_i;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (is_hlt_d) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            if (is_ldi_d) begin
              imm_q <= mem_data_i;
            end
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          if (pc_wr_enable_i) begin
            pc_q <= pc_next_d;
          end
          state_q <= S_FETCH;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_FETCH;
        end
      endcase
    end
  end

  assign counter_o = state_q[1:0];
  assign iin_o     = iin_q;
  assign imm_o     = imm_q;
  assign pc_o      = pc_q;
  assign halted_o  = halted_q;

endmodule
